// File: rtl/uart_frame_to_axi_cmd_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : uart_frame_to_axi_cmd_if
//  Purpose  : Bundles the byte-stream input, burst-request output, write-beat
//             output and status signals of uart_frame_to_axi_cmd.
//  Ports    : byte stream  - i_byte, i_byte_valid, o_byte_ready
//             request      - o_req_valid, i_req_ready, o_req_addr, o_req_len,
//                            o_req_write
//             write beats  - o_beat_data, o_beat_last, o_beat_valid,
//                            i_beat_ready
//             status       - o_busy, o_frame_err, o_frame_cnt
//             Names carry the direction seen from the parser.
//             master = parser side, slave = environment side.
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_frame_to_axi_cmd_if;
   logic [7:0]   i_byte;
   logic         i_byte_valid;
   logic         o_byte_ready;
   logic         o_req_valid;
   logic         i_req_ready;
   logic [31:0]  o_req_addr;
   logic [7:0]   o_req_len;
   logic         o_req_write;
   logic [255:0] o_beat_data;
   logic         o_beat_last;
   logic         o_beat_valid;
   logic         i_beat_ready;
   logic         o_busy;
   logic         o_frame_err;
   logic [15:0]  o_frame_cnt;

   modport master (
      input  i_byte, i_byte_valid, i_req_ready, i_beat_ready,
      output o_byte_ready, o_req_valid, o_req_addr, o_req_len, o_req_write,
             o_beat_data, o_beat_last, o_beat_valid, o_busy, o_frame_err,
             o_frame_cnt
   );

   modport slave (
      output i_byte, i_byte_valid, i_req_ready, i_beat_ready,
      input  o_byte_ready, o_req_valid, o_req_addr, o_req_len, o_req_write,
             o_beat_data, o_beat_last, o_beat_valid, o_busy, o_frame_err,
             o_frame_cnt
   );
endinterface
`default_nettype wire

// File: rtl/uart_frame_to_axi_cmd.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : uart_frame_to_axi_cmd
//  Purpose  : Parses framed commands from the UART byte stream
//             (HDR, CMD, ADDR[4] MSB first, LEN, write payload) into one
//             burst request per frame, and packs write payload into 256-bit
//             beats (first byte in [7:0]) with a last flag.
//  Ports    : axi_clk - clock
//             rstn    - asynchronous active-low reset
//             bus     - uart_frame_to_axi_cmd_if.master (byte stream in,
//                       request out, beats out, busy/error/frame count)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_frame_to_axi_cmd #(
   parameter logic [7:0]  HDR_BYTE    = 8'hA5,
   parameter logic [7:0]  MAX_LEN     = 8'd15,
   parameter logic [31:0] TIMEOUT_CYC = 32'd1000000
) (
   input  wire                     axi_clk,
   input  wire                     rstn,
   uart_frame_to_axi_cmd_if.master bus
);

   localparam logic [7:0] c_CMD_WRITE = 8'h01;
   localparam logic [7:0] c_CMD_READ  = 8'h02;

   typedef enum logic [2:0] {
      S_HUNT = 3'd0,
      S_CMD  = 3'd1,
      S_ADDR = 3'd2,
      S_LEN  = 3'd3,
      S_DATA = 3'd4,
      S_REQ  = 3'd5,
      S_BEAT = 3'd6
   } state_t;

   state_t        r_state;
   state_t        w_state_next;

   logic          r_byte_ready;
   logic [31:0]   r_addr;
   logic [1:0]    r_addr_cnt;
   logic          r_write;
   logic [7:0]    r_len;
   logic [4:0]    r_byte_cnt;
   logic [7:0]    r_beat_cnt;
   logic [255:0]  r_beat_data;
   logic          r_beat_last;
   logic [31:0]   r_idle_cnt;
   logic          r_frame_err;
   logic [15:0]   r_frame_cnt;

   logic          w_byte_hs;
   logic          w_req_hs;
   logic          w_beat_hs;
   logic          w_idle_cnt_en;
   logic          w_timeout;
   logic          w_cmd_ok;
   logic          w_len_bad;
   logic          w_frame_err;
   logic          w_frame_done;

   // o_byte_ready is registered so it stays low while rstn is asserted even
   // though the reset state (HUNT) accepts bytes.
   assign w_byte_hs     = bus.i_byte_valid & r_byte_ready;
   assign w_req_hs      = (r_state == S_REQ)  & bus.i_req_ready;
   assign w_beat_hs     = (r_state == S_BEAT) & bus.i_beat_ready;
   assign w_idle_cnt_en = (r_state == S_CMD) || (r_state == S_ADDR) ||
                          (r_state == S_LEN) || (r_state == S_DATA);
   // Fires on the cycle the idle count would reach TIMEOUT_CYC; a byte
   // arriving in that same cycle takes priority.
   assign w_timeout     = w_idle_cnt_en & ~w_byte_hs &
                          (r_idle_cnt == (TIMEOUT_CYC - 32'd1));
   assign w_cmd_ok      = (bus.i_byte == c_CMD_WRITE) || (bus.i_byte == c_CMD_READ);
   assign w_len_bad     = (bus.i_byte > MAX_LEN);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge axi_clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_HUNT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next state, error pulse and frame-completion strobes
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_frame_err  = 1'b0;
      w_frame_done = 1'b0;
      if (w_timeout) begin
         w_state_next = S_HUNT;
         w_frame_err  = 1'b1;
      end else begin
         case (r_state)
            S_HUNT: begin
               if (w_byte_hs && (bus.i_byte == HDR_BYTE)) w_state_next = S_CMD;
            end
            S_CMD: begin
               // A repeated header byte is an invalid command, not a resync.
               if (w_byte_hs) begin
                  if (w_cmd_ok) begin
                     w_state_next = S_ADDR;
                  end else begin
                     w_state_next = S_HUNT;
                     w_frame_err  = 1'b1;
                  end
               end
            end
            S_ADDR: begin
               if (w_byte_hs && (r_addr_cnt == 2'd3)) w_state_next = S_LEN;
            end
            S_LEN: begin
               if (w_byte_hs) begin
                  if (w_len_bad) begin
                     w_state_next = S_HUNT;
                     w_frame_err  = 1'b1;
                  end else begin
                     w_state_next = S_REQ;
                  end
               end
            end
            S_DATA: begin
               if (w_byte_hs && (r_byte_cnt == 5'd31)) w_state_next = S_BEAT;
            end
            S_REQ: begin
               if (w_req_hs) begin
                  if (r_write) begin
                     w_state_next = S_DATA;
                  end else begin
                     w_state_next = S_HUNT;
                     w_frame_done = 1'b1;
                  end
               end
            end
            S_BEAT: begin
               if (w_beat_hs) begin
                  if (r_beat_last) begin
                     w_state_next = S_HUNT;
                     w_frame_done = 1'b1;
                  end else begin
                     w_state_next = S_DATA;
                  end
               end
            end
            default: w_state_next = S_HUNT;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Datapath and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge axi_clk or negedge rstn) begin
      if (!rstn) begin
         r_byte_ready <= 1'b0;
         r_addr       <= '0;
         r_addr_cnt   <= '0;
         r_write      <= 1'b0;
         r_len        <= '0;
         r_byte_cnt   <= '0;
         r_beat_cnt   <= '0;
         r_beat_data  <= '0;
         r_beat_last  <= 1'b0;
         r_idle_cnt   <= '0;
         r_frame_err  <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_byte_ready <= (w_state_next != S_REQ) && (w_state_next != S_BEAT);
         r_frame_err  <= w_frame_err;

         if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;

         // Idle counter restarts on every accepted byte and state entry.
         if (!w_idle_cnt_en || w_byte_hs || (w_state_next != r_state)) begin
            r_idle_cnt <= '0;
         end else begin
            r_idle_cnt <= r_idle_cnt + 32'd1;
         end

         if (r_state != S_ADDR) begin
            r_addr_cnt <= '0;
         end else if (w_byte_hs) begin
            r_addr_cnt <= r_addr_cnt + 2'd1;
         end

         if ((r_state == S_ADDR) && w_byte_hs) begin
            r_addr <= {r_addr[23:0], bus.i_byte};
         end else if ((r_state == S_LEN) && w_byte_hs && !w_len_bad) begin
            r_addr[4:0] <= 5'd0;
         end

         if ((r_state == S_CMD) && w_byte_hs && w_cmd_ok) begin
            r_write <= (bus.i_byte == c_CMD_WRITE);
         end

         if ((r_state == S_LEN) && w_byte_hs && !w_len_bad) begin
            r_len <= bus.i_byte;
         end

         // Leaving DATA (to BEAT or on timeout) restarts lane packing.
         if (r_state != S_DATA) begin
            r_byte_cnt <= '0;
         end else if (w_byte_hs) begin
            r_byte_cnt <= r_byte_cnt + 5'd1;
         end

         if ((r_state == S_DATA) && w_byte_hs) begin
            r_beat_data[{r_byte_cnt, 3'b000} +: 8] <= bus.i_byte;
         end

         if (w_req_hs) begin
            r_beat_cnt <= '0;
         end else if (w_beat_hs && !r_beat_last) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
         end

         if ((r_state == S_DATA) && w_byte_hs && (r_byte_cnt == 5'd31)) begin
            r_beat_last <= (r_beat_cnt == r_len);
         end else if (w_beat_hs) begin
            r_beat_last <= 1'b0;
         end
      end
   end

   assign bus.o_byte_ready = r_byte_ready;
   assign bus.o_req_valid  = (r_state == S_REQ);
   assign bus.o_req_addr   = r_addr;
   assign bus.o_req_len    = r_len;
   assign bus.o_req_write  = r_write;
   assign bus.o_beat_data  = r_beat_data;
   assign bus.o_beat_last  = r_beat_last;
   assign bus.o_beat_valid = (r_state == S_BEAT);
   assign bus.o_busy       = (r_state != S_HUNT);
   assign bus.o_frame_err  = r_frame_err;
   assign bus.o_frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_to_axi_cmd.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_uart_frame_to_axi_cmd
//  Purpose  : Self-checking bench for uart_frame_to_axi_cmd. Frames are built
//             from the frame format; expected requests, beats and error
//             pulses go into scoreboard queues that a negedge monitor drains.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_to_axi_cmd;

   localparam logic [7:0] c_HDR     = 8'hA5;
   localparam logic [7:0] c_MAX_LEN = 8'd15;

   logic axi_clk = 1'b0;
   logic rstn    = 1'b0;
   always #5 axi_clk = ~axi_clk;

   uart_frame_to_axi_cmd_if bus ();

   uart_frame_to_axi_cmd #(
      .HDR_BYTE    (c_HDR),
      .MAX_LEN     (c_MAX_LEN),
      .TIMEOUT_CYC (32'd100)
   ) dut (
      .axi_clk (axi_clk),
      .rstn    (rstn),
      .bus     (bus)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic        write;
   } req_t;

   typedef struct packed {
      logic [255:0] data;
      logic         last;
   } beat_t;

   req_t        exp_req_q[$];
   beat_t       exp_beat_q[$];
   logic [7:0]  pay_q[$];
   int          exp_err_pending = 0;
   int          exp_frame_cnt   = 0;
   int          checks = 0;
   int          fails  = 0;
   int          gap_max  = 0;
   int          req_min  = 0;
   int          req_max  = 0;
   int          beat_min = 0;
   int          beat_max = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Beat k of the current payload: byte i of the beat sits at bits 8*i+7:8*i.
   function automatic logic [255:0] pack_beat(input int k);
      logic [255:0] d;
      d = '0;
      for (int i = 0; i < 32; i++) d = d | (256'(pay_q[k*32 + i]) << (8*i));
      return d;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int guard;
      repeat ($urandom_range(0, gap_max)) begin @(posedge axi_clk); #1; end
      bus.i_byte       = b;
      bus.i_byte_valid = 1'b1;
      guard            = 0;
      @(negedge axi_clk);
      while (!bus.o_byte_ready && guard < 1000) begin
         @(negedge axi_clk);
         guard++;
      end
      if (!bus.o_byte_ready) begin
         checks++;
         fails++;
         $display("FAIL byte_accept: byte %02h not accepted, ready=0 after 1000 cycles", b);
      end
      @(posedge axi_clk); #1;
      bus.i_byte_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      @(negedge axi_clk);
      while (bus.o_busy && guard < 5000) begin
         @(negedge axi_clk);
         guard++;
      end
      if (bus.o_busy) begin
         checks++;
         fails++;
         $display("FAIL wait_idle: busy=1 after 5000 cycles, required 0");
      end
      @(posedge axi_clk); #1;
   endtask

   // Sends one frame. n_send < 0 sends the full payload; a shorter count
   // leaves the frame unfinished for the caller to time out or reset.
   task automatic run_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [7:0] len, input bit incr, input int n_send);
      bit    cmd_ok;
      bit    wr;
      int    total;
      int    nsend;
      req_t  r;
      beat_t bt;
      cmd_ok = (cmd == 8'h01) || (cmd == 8'h02);
      wr     = (cmd == 8'h01);
      total  = wr ? (int'(len) + 1) * 32 : 0;
      nsend  = (n_send < 0 || n_send > total) ? total : n_send;
      pay_q.delete();
      for (int i = 0; i < total; i++) pay_q.push_back(incr ? 8'(i) : 8'($urandom));

      send_byte(c_HDR);
      if (!cmd_ok) begin
         exp_err_pending++;
         send_byte(cmd);
         wait_idle();
         return;
      end
      send_byte(cmd);
      for (int i = 0; i < 4; i++) send_byte(addr[31 - 8*i -: 8]);
      if (len > c_MAX_LEN) begin
         exp_err_pending++;
         send_byte(len);
         wait_idle();
         return;
      end
      r.addr  = {addr[31:5], 5'd0};
      r.len   = len;
      r.write = wr;
      exp_req_q.push_back(r);
      for (int k = 0; k < nsend / 32; k++) begin
         bt.data = pack_beat(k);
         bt.last = (k == int'(len));
         exp_beat_q.push_back(bt);
      end
      send_byte(len);
      for (int i = 0; i < nsend; i++) send_byte(pay_q[i]);
      if (nsend == total) begin
         exp_frame_cnt++;
         wait_idle();
         check("frame_cnt", 256'(bus.o_frame_cnt), 256'(16'(exp_frame_cnt)));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_byte_ready"}, 256'(bus.o_byte_ready), 256'(0));
      check({tag, "_req_valid"},  256'(bus.o_req_valid),  256'(0));
      check({tag, "_req_addr"},   256'(bus.o_req_addr),   256'(0));
      check({tag, "_req_len"},    256'(bus.o_req_len),    256'(0));
      check({tag, "_req_write"},  256'(bus.o_req_write),  256'(0));
      check({tag, "_beat_data"},  bus.o_beat_data,        256'(0));
      check({tag, "_beat_last"},  256'(bus.o_beat_last),  256'(0));
      check({tag, "_beat_valid"}, 256'(bus.o_beat_valid), 256'(0));
      check({tag, "_busy"},       256'(bus.o_busy),       256'(0));
      check({tag, "_frame_err"},  256'(bus.o_frame_err),  256'(0));
      check({tag, "_frame_cnt"},  256'(bus.o_frame_cnt),  256'(0));
   endtask

   // Request-ready driver: per request, ready stays low for a chosen stall.
   initial begin
      int req_wait;
      int req_stall;
      req_wait  = 0;
      req_stall = 0;
      bus.i_req_ready = 1'b0;
      forever begin
         @(posedge axi_clk); #1;
         if (bus.o_req_valid) begin
            bus.i_req_ready = (req_wait >= req_stall);
            req_wait++;
         end else begin
            req_wait        = 0;
            req_stall       = $urandom_range(req_min, req_max);
            bus.i_req_ready = (req_stall == 0);
         end
      end
   end

   // Beat-ready driver, same scheme per beat.
   initial begin
      int beat_wait;
      int beat_stall;
      beat_wait  = 0;
      beat_stall = 0;
      bus.i_beat_ready = 1'b0;
      forever begin
         @(posedge axi_clk); #1;
         if (bus.o_beat_valid) begin
            bus.i_beat_ready = (beat_wait >= beat_stall);
            beat_wait++;
         end else begin
            beat_wait        = 0;
            beat_stall       = $urandom_range(beat_min, beat_max);
            bus.i_beat_ready = (beat_stall == 0);
         end
      end
   end

   // Monitor: drains the scoreboard on handshakes, checks hold-while-stalled,
   // byte-ready low during REQ/BEAT, and error-pulse properties.
   initial begin
      req_t        prev_req;
      req_t        got_req;
      req_t        e_req;
      beat_t       prev_beat;
      beat_t       got_beat;
      beat_t       e_beat;
      bit          req_stalled;
      bit          beat_stalled;
      logic        err_prev;
      logic [15:0] cnt_prev;
      req_stalled  = 1'b0;
      beat_stalled = 1'b0;
      err_prev     = 1'b0;
      cnt_prev     = '0;
      prev_req     = '0;
      prev_beat    = '0;
      forever begin
         @(negedge axi_clk);
         if (!rstn) begin
            req_stalled  = 1'b0;
            beat_stalled = 1'b0;
            err_prev     = 1'b0;
            cnt_prev     = '0;
         end else begin
            got_req  = '{addr: bus.o_req_addr, len: bus.o_req_len, write: bus.o_req_write};
            got_beat = '{data: bus.o_beat_data, last: bus.o_beat_last};
            if (bus.o_req_valid) begin
               check("byte_ready_in_req", 256'(bus.o_byte_ready), 256'(0));
               if (req_stalled) check("req_stable", 256'(got_req), 256'(prev_req));
               if (bus.i_req_ready) begin
                  req_stalled = 1'b0;
                  if (exp_req_q.size() == 0) begin
                     checks++;
                     fails++;
                     $display("FAIL unexpected_req: got addr %08h, required no request", got_req.addr);
                  end else begin
                     e_req = exp_req_q.pop_front();
                     check("req_addr",  256'(got_req.addr),  256'(e_req.addr));
                     check("req_len",   256'(got_req.len),   256'(e_req.len));
                     check("req_write", 256'(got_req.write), 256'(e_req.write));
                  end
               end else begin
                  req_stalled = 1'b1;
                  prev_req    = got_req;
               end
            end else begin
               req_stalled = 1'b0;
            end

            if (bus.o_beat_valid) begin
               check("byte_ready_in_beat", 256'(bus.o_byte_ready), 256'(0));
               if (beat_stalled) begin
                  check("beat_data_stable", got_beat.data, prev_beat.data);
                  check("beat_last_stable", 256'(got_beat.last), 256'(prev_beat.last));
               end
               if (bus.i_beat_ready) begin
                  beat_stalled = 1'b0;
                  if (exp_beat_q.size() == 0) begin
                     checks++;
                     fails++;
                     $display("FAIL unexpected_beat: got last=%0d, required no beat", got_beat.last);
                  end else begin
                     e_beat = exp_beat_q.pop_front();
                     check("beat_data", got_beat.data, e_beat.data);
                     check("beat_last", 256'(got_beat.last), 256'(e_beat.last));
                  end
               end else begin
                  beat_stalled = 1'b1;
                  prev_beat    = got_beat;
               end
            end else begin
               beat_stalled = 1'b0;
            end

            if (bus.o_frame_err) begin
               checks++;
               if (exp_err_pending == 0) begin
                  fails++;
                  $display("FAIL unexpected_frame_err: got pulse, required none");
               end else begin
                  exp_err_pending--;
               end
               check("err_one_cycle", 256'(err_prev), 256'(0));
               check("err_cnt_exclusive", 256'(bus.o_frame_cnt), 256'(cnt_prev));
            end
            err_prev = bus.o_frame_err;
            cnt_prev = bus.o_frame_cnt;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", checks, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bus.i_byte       = 8'h00;
      bus.i_byte_valid = 1'b0;

      // Reset state
      repeat (4) @(posedge axi_clk);
      @(negedge axi_clk);
      check_all_zero("rst");
      rstn = 1'b1;
      @(posedge axi_clk); #1;
      @(posedge axi_clk); #1;

      // Directed write: addr 0x1000, len 0, payload 00..1F, ready always high
      run_frame(8'h01, 32'h0000_1000, 8'd0, 1'b1, -1);

      // Directed read: addr bits [4:0] cleared
      run_frame(8'h02, 32'h1234_567F, 8'd3, 1'b0, -1);

      // Backpressure: 20-cycle request stall, 10-cycle stall per beat
      req_min = 20;  req_max  = 20;
      beat_min = 10; beat_max = 10;
      run_frame(8'h01, 32'h8000_0020, 8'd1, 1'b0, -1);

      // Randomized gaps and stalls from here on
      gap_max = 3;
      req_min = 0;  req_max  = 4;
      beat_min = 0; beat_max = 4;

      // Bad command, header byte as command, oversize length
      run_frame(8'h07, 32'h0, 8'd0, 1'b0, -1);
      run_frame(c_HDR, 32'h0, 8'd0, 1'b0, -1);
      run_frame(8'h01, 32'h0000_0000, 8'h10, 1'b0, -1);
      check("frame_cnt_after_errs", 256'(bus.o_frame_cnt), 256'(16'(exp_frame_cnt)));

      // Garbage before a valid frame
      send_byte(8'h11);
      send_byte(8'h22);
      run_frame(8'h02, 32'hDEAD_BEEF, 8'd7, 1'b0, -1);

      // Boundary length MAX_LEN on a read
      run_frame(8'h02, 32'h0000_0040, c_MAX_LEN, 1'b0, -1);

      // Timeout after 10 payload bytes
      run_frame(8'h01, 32'h0000_2000, 8'd0, 1'b0, 10);
      exp_err_pending++;
      cnt = 0;
      do begin
         @(posedge axi_clk); #1;
         cnt++;
      end while (!bus.o_frame_err && cnt < 300);
      check("timeout_latency", 256'(cnt), 256'(100));
      wait_idle();
      check("frame_cnt_after_timeout", 256'(bus.o_frame_cnt), 256'(16'(exp_frame_cnt)));
      run_frame(8'h01, 32'h0000_3000, 8'd0, 1'b0, -1);

      // Randomized frames
      for (int f = 0; f < 8; f++) begin
         run_frame(($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02, $urandom,
                   8'($urandom_range(0, 3)), 1'b0, -1);
      end

      // Asynchronous reset in the middle of the second beat
      run_frame(8'h01, 32'hCAFE_0040, 8'd1, 1'b0, 40);
      repeat (2) begin @(posedge axi_clk); #1; end
      #2;
      rstn = 1'b0;
      #1;
      check_all_zero("midrst");
      exp_frame_cnt = 0;
      repeat (3) @(posedge axi_clk);
      @(negedge axi_clk);
      rstn = 1'b1;
      @(posedge axi_clk); #1;
      @(posedge axi_clk); #1;
      run_frame(8'h01, 32'h0001_0000, 8'd2, 1'b0, -1);

      repeat (20) @(posedge axi_clk);
      #1;
      check("req_queue_empty",  256'(exp_req_q.size()),  256'(0));
      check("beat_queue_empty", 256'(exp_beat_q.size()), 256'(0));
      check("err_pending_zero", 256'(exp_err_pending),   256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
